// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register widths, the load-op encoding, and the MEM/WB stage record.
package cpu_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LB      = 3'd1,
        LBU     = 3'd2,
        LH      = 3'd3,
        LHU     = 3'd4,
        LW      = 3'd5
    } ldop_e;

    typedef struct packed {
        logic                  valid;
        logic                  wreg;
        logic [RegAddrBus-1:0] wd;
        logic [RegBus-1:0]     wdata;
        ldop_e                 ldop;
        logic [1:0]            addr_lo;
    } wb_stage_t;

    // A bubble is also the reset image of the stage.
    localparam wb_stage_t STAGE_BUBBLE = '{
        valid:   1'b0,
        wreg:    1'b0,
        wd:      '0,
        wdata:   ZeroWord,
        ldop:    LD_NONE,
        addr_lo: 2'b00
    };

    function automatic logic is_load(input ldop_e op);
        return op != LD_NONE;
    endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// load_align: big-endian lane select and sign/zero extension of a RAM word,
// plus the misalignment flag for halfword and word loads.
module load_align
    import cpu_pkg::*;
(
    input  logic [RegBus-1:0] i_rdata,
    input  ldop_e             i_ldop,
    input  logic [1:0]        i_addr_lo,
    output logic [RegBus-1:0] o_data,
    output logic              o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte address 0 is the most significant lane.
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

    always_comb begin
        o_data = ZeroWord;
        case (i_ldop)
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LBU:     o_data = {24'h000000, w_byte};
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LHU:     o_data = {16'h0000, w_half};
            LW:      o_data = i_rdata;
            default: o_data = ZeroWord;
        endcase
    end

    always_comb begin
        o_misalign = 1'b0;
        case (i_ldop)
            LH, LHU: o_misalign = i_addr_lo[0];
            LW:      o_misalign = |i_addr_lo;
            default: o_misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with load alignment, hold-data capture and a retire counter.
// Optional HI/LO writeback path is enabled by defining MEM_WB_HILO_EN.
module mem_wb
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_mem,
    input  logic                  stall_wb,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_wreg,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic [RegBus-1:0]     mem_wdata,
    input  logic [2:0]            mem_ldop,
    input  logic [1:0]            mem_addr_lo,
`ifdef MEM_WB_HILO_EN
    input  logic                  mem_whilo,
    input  logic [RegBus-1:0]     mem_hi,
    input  logic [RegBus-1:0]     mem_lo,
    output logic                  wb_whilo,
    output logic [RegBus-1:0]     wb_hi,
    output logic [RegBus-1:0]     wb_lo,
`endif
    input  logic [RegBus-1:0]     dmem_rdata,
    output logic                  wb_we,
    output logic [RegAddrBus-1:0] wb_waddr,
    output logic [RegBus-1:0]     wb_wdata,
    output logic                  wb_align_err,
    output logic [RegBus-1:0]     wb_retire_cnt
);

    wb_stage_t         r_stage;
    wb_stage_t         w_stage_in;
    logic              r_held;
    logic [RegBus-1:0] r_hold_data;
    logic [RegBus-1:0] r_retire_cnt;
    logic [RegBus-1:0] w_load_data;
    logic [RegBus-1:0] w_live_data;
    logic              w_misalign;
    logic              w_advance;

    assign w_stage_in = '{
        valid:   mem_valid,
        wreg:    mem_wreg,
        wd:      mem_wd,
        wdata:   mem_wdata,
        ldop:    ldop_e'(mem_ldop),
        addr_lo: mem_addr_lo
    };

    // Stage control: flush beats everything, stall_wb freezes WB, and stall_mem
    // alone lets WB drain while a bubble enters behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= STAGE_BUBBLE;
        end else if (flush) begin
            r_stage <= STAGE_BUBBLE;
        end else if (stall_wb) begin
            r_stage <= r_stage;
        end else if (stall_mem) begin
            r_stage <= STAGE_BUBBLE;
        end else begin
            r_stage <= w_stage_in;
        end
    end

    load_align u_load_align (
        .i_rdata    (dmem_rdata),
        .i_ldop     (r_stage.ldop),
        .i_addr_lo  (r_stage.addr_lo),
        .o_data     (w_load_data),
        .o_misalign (w_misalign)
    );

    // The RAM output is only trustworthy in the first WB cycle, so freeze it then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held      <= 1'b0;
            r_hold_data <= ZeroWord;
        end else if (flush || !stall_wb) begin
            r_held      <= 1'b0;
        end else if (!r_held && r_stage.valid && is_load(r_stage.ldop)) begin
            r_held      <= 1'b1;
            r_hold_data <= w_load_data;
        end
    end

    assign w_advance = r_stage.valid & ~stall_wb & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= ZeroWord;
        end else if (w_advance) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign w_live_data   = is_load(r_stage.ldop) ? w_load_data : r_stage.wdata;
    assign wb_wdata      = r_held ? r_hold_data : w_live_data;
    assign wb_waddr      = r_stage.wd;
    assign wb_align_err  = r_stage.valid & w_misalign;
    assign wb_we         = r_stage.valid & r_stage.wreg & (r_stage.wd != '0) & ~w_misalign;
    assign wb_retire_cnt = r_retire_cnt;

`ifdef MEM_WB_HILO_EN
    logic              r_whilo;
    logic [RegBus-1:0] r_hi;
    logic [RegBus-1:0] r_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_whilo <= 1'b0;
            r_hi    <= ZeroWord;
            r_lo    <= ZeroWord;
        end else if (flush || (!stall_wb && stall_mem)) begin
            r_whilo <= 1'b0;
            r_hi    <= ZeroWord;
            r_lo    <= ZeroWord;
        end else if (!stall_wb) begin
            r_whilo <= mem_whilo;
            r_hi    <= mem_hi;
            r_lo    <= mem_lo;
        end
    end

    assign wb_whilo = r_stage.valid & r_whilo;
    assign wb_hi    = r_hi;
    assign wb_lo    = r_lo;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed scenarios plus randomized traffic
// checked against a behavioural model of the WB stage.
module tb_mem_wb;

    logic        clk;
    logic        rst_n;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic        mem_valid;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ldop;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dmem_rdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_align_err;
    logic [31:0] wb_retire_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural picture of what currently sits in WB.
    logic        m_valid, m_wreg, m_held;
    logic [4:0]  m_wd;
    logic [31:0] m_wdata, m_hold, m_cnt;
    logic [2:0]  m_ldop;
    logic [1:0]  m_addr;

    logic        exp_we, exp_err;
    logic [31:0] exp_wdata;
    logic [31:0] exp_q[$];

    mem_wb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_mem     (stall_mem),
        .stall_wb      (stall_wb),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_wreg      (mem_wreg),
        .mem_wd        (mem_wd),
        .mem_wdata     (mem_wdata),
        .mem_ldop      (mem_ldop),
        .mem_addr_lo   (mem_addr_lo),
        .dmem_rdata    (dmem_rdata),
        .wb_we         (wb_we),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
        .wb_align_err  (wb_align_err),
        .wb_retire_cnt (wb_retire_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] d);
        int unsigned b, h, sh;
        sh = 8 * (3 - int'(a));
        b  = (d >> sh) & 32'hFF;
        sh = a[1] ? 0 : 16;
        h  = (d >> sh) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return h;
            3'd5:    return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] op, input logic [1:0] a);
        if (op == 3'd3 || op == 3'd4) return (int'(a) % 2) != 0;
        if (op == 3'd5) return a != 2'd0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wreg = 0; m_held = 0; m_wd = 0;
        m_wdata = 0; m_hold = 0; m_cnt = 0; m_ldop = 0; m_addr = 0;
    endtask

    task automatic compute_exp();
        logic mis;
        mis       = m_valid && ref_misaligned(m_ldop, m_addr);
        exp_err   = mis;
        exp_we    = m_valid && m_wreg && (m_wd != 0) && !mis;
        exp_wdata = m_held ? m_hold : ((m_ldop == 0) ? m_wdata : ref_load(m_ldop, m_addr, dmem_rdata));
    endtask

    // Applies one rising edge to the model using the inputs presented at that edge.
    task automatic model_edge();
        if (m_valid && !stall_wb && !flush) m_cnt = m_cnt + 1;
        if (flush) begin
            m_valid = 0; m_wreg = 0; m_ldop = 0; m_held = 0;
        end else if (stall_wb) begin
            if (!m_held && m_valid && m_ldop != 0) begin
                m_hold = ref_load(m_ldop, m_addr, dmem_rdata);
                m_held = 1;
            end
        end else begin
            m_held = 0;
            if (stall_mem) begin
                m_valid = 0; m_wreg = 0; m_ldop = 0;
            end else begin
                m_valid = mem_valid; m_wreg = mem_wreg; m_wd = mem_wd;
                m_wdata = mem_wdata; m_ldop = mem_ldop; m_addr = mem_addr_lo;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_insn(input logic v, input logic wr, input logic [4:0] wd,
                              input logic [31:0] wdata, input logic [2:0] op, input logic [1:0] a);
        mem_valid = v; mem_wreg = wr; mem_wd = wd;
        mem_wdata = wdata; mem_ldop = op; mem_addr_lo = a;
    endtask

    task automatic drive_idle();
        drive_insn(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; stall_mem = 0; stall_wb = 0; flush = 0; dmem_rdata = 32'hA5A5A5A5;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({wb_we, wb_align_err, wb_waddr, wb_wdata, wb_retire_cnt} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_state: we=%b err=%b waddr=%0d wdata=%h cnt=%h, required all zero",
                     wb_we, wb_align_err, wb_waddr, wb_wdata, wb_retire_cnt);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_lb_lbu();
        drive_insn(1, 1, 5'd3, 32'h0, 3'd1, 2'd1);
        advance();
        dmem_rdata = 32'h12803456;
        drive_insn(1, 1, 5'd4, 32'h0, 3'd2, 2'd1);
        #1;
        n_cmp++;
        if (wb_wdata !== 32'hFFFFFF80 || wb_we !== 1'b1 || wb_waddr !== 5'd3) begin
            n_fail++;
            $display("FAIL lb_sign: wdata=%h we=%b waddr=%0d, required FFFFFF80 1 3", wb_wdata, wb_we, wb_waddr);
        end
        advance();
        drive_idle();
        #1;
        n_cmp++;
        if (wb_wdata !== 32'h00000080 || wb_we !== 1'b1 || wb_waddr !== 5'd4) begin
            n_fail++;
            $display("FAIL lbu_zero: wdata=%h we=%b waddr=%0d, required 00000080 1 4", wb_wdata, wb_we, wb_waddr);
        end
        advance();
    endtask

    task automatic test_misalign();
        logic [31:0] c0;
        drive_insn(1, 1, 5'd6, 32'h0, 3'd3, 2'd1);
        advance();
        drive_idle();
        dmem_rdata = 32'h11223344;
        #1;
        c0 = m_cnt;
        n_cmp++;
        if (wb_align_err !== 1'b1 || wb_we !== 1'b0 || wb_retire_cnt !== c0) begin
            n_fail++;
            $display("FAIL lh_misalign: err=%b we=%b cnt=%h, required 1 0 %h", wb_align_err, wb_we, wb_retire_cnt, c0);
        end
        advance();
        #1;
        n_cmp++;
        if (wb_retire_cnt !== c0 + 32'd1 || wb_align_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_retire: cnt=%h err=%b, required %h 0", wb_retire_cnt, wb_align_err, c0 + 32'd1);
        end
    endtask

    task automatic test_hold();
        logic [31:0] c0;
        drive_insn(1, 1, 5'd5, 32'h0, 3'd5, 2'd0);
        advance();
        drive_insn(1, 1, 5'd7, 32'h77, 3'd0, 2'd0);
        dmem_rdata = 32'hDEADBEEF;
        stall_wb = 1;
        #1;
        c0 = wb_retire_cnt;
        n_cmp++;
        if (wb_wdata !== 32'hDEADBEEF || wb_we !== 1'b1 || wb_waddr !== 5'd5) begin
            n_fail++;
            $display("FAIL lw_first: wdata=%h we=%b waddr=%0d, required DEADBEEF 1 5", wb_wdata, wb_we, wb_waddr);
        end
        for (int i = 0; i < 3; i++) begin
            advance();
            dmem_rdata = 32'h0;
            if (i == 2) stall_wb = 0;
            #1;
            n_cmp++;
            if (wb_wdata !== 32'hDEADBEEF || wb_we !== 1'b1 || wb_retire_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL lw_hold%0d: wdata=%h we=%b cnt=%h, required DEADBEEF 1 %h",
                         i, wb_wdata, wb_we, wb_retire_cnt, m_cnt);
            end
        end
        advance();
        drive_idle();
        #1;
        n_cmp++;
        if (wb_retire_cnt !== c0 + 32'd1 || wb_wdata !== 32'h77 || wb_waddr !== 5'd7) begin
            n_fail++;
            $display("FAIL hold_release: cnt=%h wdata=%h waddr=%0d, required %h 00000077 7",
                     wb_retire_cnt, wb_wdata, wb_waddr, c0 + 32'd1);
        end
        advance();
    endtask

    task automatic test_bubble_flush();
        logic [31:0] c0;
        drive_insn(1, 1, 5'd8, 32'h1234, 3'd0, 2'd0);
        stall_mem = 1;
        advance();
        stall_mem = 0;
        #1;
        c0 = m_cnt;
        n_cmp++;
        if (wb_we !== 1'b0 || wb_retire_cnt !== c0) begin
            n_fail++;
            $display("FAIL bubble: we=%b cnt=%h, required 0 %h", wb_we, wb_retire_cnt, c0);
        end
        advance();
        drive_idle();
        #1;
        n_cmp++;
        if (wb_we !== 1'b1 || wb_wdata !== 32'h1234 || wb_waddr !== 5'd8) begin
            n_fail++;
            $display("FAIL after_bubble: we=%b wdata=%h waddr=%0d, required 1 00001234 8", wb_we, wb_wdata, wb_waddr);
        end
        flush = 1; stall_wb = 1;
        advance();
        flush = 0; stall_wb = 0;
        #1;
        n_cmp++;
        if (wb_we !== 1'b0 || wb_retire_cnt !== c0) begin
            n_fail++;
            $display("FAIL flush_over_stall: we=%b cnt=%h, required 0 %h", wb_we, wb_retire_cnt, c0);
        end
    endtask

    task automatic test_zero_reg_wrap();
        drive_insn(1, 1, 5'd0, 32'h55, 3'd0, 2'd0);
        advance();
        drive_idle();
        #1;
        n_cmp++;
        if (wb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_write: we=%b, required 0", wb_we);
        end
        advance();
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        drive_insn(1, 1, 5'd9, 32'h99, 3'd0, 2'd0);
        advance();
        drive_idle();
        #1;
        n_cmp++;
        if (wb_retire_cnt !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL cnt_preset: cnt=%h, required FFFFFFFF", wb_retire_cnt);
        end
        advance();
        #1;
        n_cmp++;
        if (wb_retire_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL cnt_wrap: cnt=%h, required 00000000", wb_retire_cnt);
        end
    endtask

    task automatic test_reset_mid_hold();
        drive_insn(1, 1, 5'd9, 32'h0, 3'd5, 2'd0);
        advance();
        drive_idle();
        dmem_rdata = 32'hCAFEF00D;
        stall_wb = 1;
        advance();
        dmem_rdata = 32'h0;
        #3;
        rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if ({wb_we, wb_align_err, wb_waddr, wb_wdata, wb_retire_cnt} !== 71'd0) begin
            n_fail++;
            $display("FAIL async_reset: we=%b err=%b waddr=%0d wdata=%h cnt=%h, required all zero",
                     wb_we, wb_align_err, wb_waddr, wb_wdata, wb_retire_cnt);
        end
        @(negedge clk);
        rst_n = 1; stall_wb = 0;
        drive_insn(1, 1, 5'd10, 32'h0, 3'd5, 2'd0);
        advance();
        drive_idle();
        dmem_rdata = 32'h11223344;
        #1;
        n_cmp++;
        if (wb_wdata !== 32'h11223344 || wb_we !== 1'b1 || wb_waddr !== 5'd10) begin
            n_fail++;
            $display("FAIL post_reset_load: wdata=%h we=%b waddr=%0d, required 11223344 1 10", wb_wdata, wb_we, wb_waddr);
        end
        advance();
        #1;
        n_cmp++;
        if (wb_retire_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL post_reset_retire: cnt=%h, required 00000001", wb_retire_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] d;
            d = $urandom;
            drive_insn(1, 1, 5'($urandom_range(1, 31)), d, 3'd0, 2'd0);
            exp_q.push_back(d);
            if (i > 0) begin
                #1;
                want = exp_q.pop_front();
                n_cmp++;
                if (wb_wdata !== want || wb_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: wdata=%h we=%b, required %h 1", i, wb_wdata, wb_we, want);
                end
            end
            advance();
        end
        drive_idle();
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall_wb   = ($urandom_range(0, 3) == 0);
            stall_mem  = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 11) == 0);
            dmem_rdata = $urandom;
            drive_insn($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
            #1;
            compute_exp();
            n_cmp++;
            if (wb_we !== exp_we || wb_align_err !== exp_err || wb_retire_cnt !== m_cnt ||
                (m_valid && wb_wdata !== exp_wdata) || (exp_we && wb_waddr !== m_wd)) begin
                n_fail++;
                $display("FAIL random_%0d: we=%b err=%b waddr=%0d wdata=%h cnt=%h, required we=%b err=%b waddr=%0d wdata=%h cnt=%h",
                         i, wb_we, wb_align_err, wb_waddr, wb_wdata, wb_retire_cnt,
                         exp_we, exp_err, m_wd, exp_wdata, m_cnt);
            end
            advance();
        end
        stall_wb = 0; stall_mem = 0; flush = 0;
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lb_lbu();
        test_misalign();
        test_hold();
        test_bubble_flush();
        test_zero_reg_wrap();
        test_reset_mid_hold();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
